// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS instruction-fetch stage.
//   fetch_state_e : fetch sequencer states (IDLE, REQ, WAIT, HOLD)
//   NOP_INST      : instruction word driven as a pipeline bubble
//   PC_STEP       : byte distance between consecutive instructions
//   align_pc()    : clears the two byte-offset bits of a fetch address
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and memory.
//   imem_req    : fetch request valid (fetch unit -> memory)
//   imem_addr   : fetch address, taken by memory on the accept cycle
//   imem_ready  : memory accepts the request when req && ready
//   imem_rvalid : response valid, at least one cycle after accept
//   imem_rdata  : returned instruction word
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf
// One-entry {pc, inst} holding register. Catches a memory response that lands
// while decode is stalled so the fetch unit can replay it once the stall ends.
//   clk, rst : clock, asynchronous active-high reset
//   i_load   : capture i_pc/i_inst and mark the entry valid
//   i_clear  : empty the entry (i_load wins if both are set)
//   i_pc     : PC+4 of the captured instruction
//   i_inst   : captured instruction word
//   o_valid  : entry holds an instruction
//   o_pc     : stored PC+4
//   o_inst   : stored instruction word
// -----------------------------------------------------------------------------
module if_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the fetch PC, keeps at most one request in
// flight to instruction memory, and presents the pc/inst pair sampled every
// cycle by the enable-less IF/ID register. Stall is done by holding the
// outputs, flush by driving a NOP bubble.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   stall_in       : hazard unit holds the current outputs
//   redirect_valid : taken branch/jump; flush and refetch
//   redirect_pc    : new fetch address (bits [1:0] forced to 0)
//   imem           : instruction-memory bus (master side)
//   pc_out         : PC+4 of the instruction on inst_out
//   inst_out       : instruction word, NOP when out_valid is low
//   out_valid      : inst_out holds a real instruction
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | first cycle after reset, nothing requested yet
// REQ     | imem_req high, waiting for memory to accept fetch_pc
// WAIT    | request accepted, waiting for the response
// HOLD    | response parked in the skid buffer while decode is stalled
// -----------------------------------------------------------------------------
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_in,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_out,
    output logic [31:0]            inst_out,
    output logic                   out_valid
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_nxt;
    logic         r_drop;
    logic         w_drop_nxt;

    logic [31:0]  r_pc_out;
    logic [31:0]  w_pc_out_nxt;
    logic [31:0]  r_inst_out;
    logic [31:0]  w_inst_out_nxt;
    logic         r_out_valid;
    logic         w_out_valid_nxt;

    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_pc_inc;
    logic         w_accept;
    logic         w_out_busy;
    logic         w_load_resp;
    logic         w_load_skid;

    logic         w_skid_load;
    logic         w_skid_clear;
    logic         w_skid_valid;
    logic [31:0]  w_skid_pc;
    logic [31:0]  w_skid_inst;

    assign w_redirect_pc = align_pc(redirect_pc);
    assign w_pc_inc      = r_fetch_pc + PC_STEP;
    assign w_accept      = (r_state == FS_REQ) && imem.imem_ready;
    // The output register is only "owned" by decode while it shows a real
    // instruction; a stall over a bubble does not block a new load.
    assign w_out_busy    = r_out_valid && stall_in;

    assign imem.imem_req  = (r_state == FS_REQ);
    assign imem.imem_addr = r_fetch_pc;

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (w_pc_inc),
        .i_inst  (imem.imem_rdata),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FS_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop      <= 1'b0;
            r_pc_out    <= 32'h0;
            r_inst_out  <= NOP_INST;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_inst_out  <= w_inst_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Sequencer: next state, fetch PC, drop flag and skid control.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        w_load_resp    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;

        case (r_state)
            FS_IDLE: begin
                w_state_nxt = FS_REQ;
            end

            FS_REQ: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                end
                if (w_accept) begin
                    w_state_nxt = FS_WAIT;
                    // Request already went out for the stale PC; its
                    // response must be thrown away.
                    w_drop_nxt  = redirect_valid;
                end
            end

            FS_WAIT: begin
                if (imem.imem_rvalid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = FS_REQ;
                    if (redirect_valid) begin
                        w_fetch_pc_nxt = w_redirect_pc;
                    end else if (!r_drop) begin
                        w_fetch_pc_nxt = w_pc_inc;
                        if (w_out_busy) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = FS_HOLD;
                        end else begin
                            w_load_resp = 1'b1;
                        end
                    end
                end else if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_drop_nxt     = 1'b1;
                end
            end

            FS_HOLD: begin
                if (redirect_valid) begin
                    w_skid_clear   = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = FS_REQ;
                end else if (!stall_in) begin
                    w_skid_clear = 1'b1;
                    w_load_skid  = w_skid_valid;
                    w_state_nxt  = FS_REQ;
                end
            end

            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    // Output register: redirect > stall-hold > load > bubble.
    always_comb begin
        w_pc_out_nxt    = r_pc_out;
        w_inst_out_nxt  = r_inst_out;
        w_out_valid_nxt = r_out_valid;

        if (redirect_valid) begin
            w_out_valid_nxt = 1'b0;
            w_inst_out_nxt  = NOP_INST;
        end else if (!w_out_busy) begin
            if (w_load_resp) begin
                w_pc_out_nxt    = w_pc_inc;
                w_inst_out_nxt  = imem.imem_rdata;
                w_out_valid_nxt = 1'b1;
            end else if (w_load_skid) begin
                w_pc_out_nxt    = w_skid_pc;
                w_inst_out_nxt  = w_skid_inst;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
                w_inst_out_nxt  = NOP_INST;
            end
        end
    end

    assign pc_out    = r_pc_out;
    assign inst_out  = r_inst_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scenarios followed by a randomized run. A memory model answers
// accepted requests after a programmable latency with data = addr ^ A5A5_0000.
// The reference model tracks the instruction stream (expected next fetch
// address, queue of instructions owed to decode, current expected outputs).
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        out_valid;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .pc_out         (pc_out),
        .inst_out       (inst_out),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // memory model
    bit          m_busy;
    bit          m_keep;
    logic [31:0] m_addr;
    logic [31:0] m_exp;
    int          m_cnt;
    int          m_lat;
    bit          lat_rand;

    // reference model
    logic [31:0] next_addr;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] acc_log[$];
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    int          out_count;
    int          a0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic rv;
        logic acc;
        stall_in            = st;
        redirect_valid      = rd;
        redirect_pc         = rpc;
        imem_bus.imem_ready = rdy;
        rv = 1'b0;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) rv = 1'b1;
        end
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rv ? mem_word(m_addr) : $urandom();
        acc = imem_bus.imem_req && rdy;
        if (rv) begin
            m_busy = 1'b0;
            if (m_keep && !rd) begin
                exp_pc_q.push_back(m_exp + 32'd4);
                exp_inst_q.push_back(mem_word(m_exp));
                next_addr = m_exp + 32'd4;
            end
        end
        if (acc) begin
            check("single_outstanding", {31'b0, m_busy}, 32'd0);
            check("fetch_addr", imem_bus.imem_addr, next_addr);
            acc_log.push_back(imem_bus.imem_addr);
            m_busy = 1'b1;
            m_addr = imem_bus.imem_addr;
            m_exp  = next_addr;
            m_keep = !rd;
            m_cnt  = lat_rand ? int'($urandom_range(1, 3)) : m_lat;
        end
        if (rd) begin
            m_keep = 1'b0;
            exp_pc_q.delete();
            exp_inst_q.delete();
            next_addr = rpc & ~32'd3;
        end

        @(posedge clk);
        #1;
        if (rd) begin
            e_valid = 1'b0;
            e_inst  = 32'h0;
        end else if (st && e_valid) begin
            e_valid = e_valid;
        end else if (exp_pc_q.size() > 0) begin
            e_pc    = exp_pc_q.pop_front();
            e_inst  = exp_inst_q.pop_front();
            e_valid = 1'b1;
            out_count++;
        end else begin
            e_valid = 1'b0;
            e_inst  = 32'h0;
        end
        check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        check("pc_out", pc_out, e_pc);
        check("inst_out", inst_out, e_inst);
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        stall_in             = 1'b0;
        redirect_valid       = 1'b0;
        redirect_pc          = 32'h0;
        imem_bus.imem_ready  = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        #2;
        check("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        check("rst_addr", imem_bus.imem_addr, RESET_PC);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        m_busy    = 1'b0;
        m_keep    = 1'b0;
        next_addr = RESET_PC;
        exp_pc_q.delete();
        exp_inst_q.delete();
        acc_log.delete();
        e_valid = 1'b0;
        e_pc    = 32'h0;
        e_inst  = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("req_low_first_cycle", {31'b0, imem_bus.imem_req}, 32'd0);
    endtask

    task automatic wait_accepts(input int target, input int budget);
        int n = 0;
        while (acc_log.size() < target && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("accept_timeout", {31'b0, acc_log.size() >= target}, 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        check("req_timeout", {31'b0, imem_bus.imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        lat_rand  = 1'b0;
        m_lat     = 1;
        out_count = 0;
        #1;

        // Zero-wait sequential fetch, then redirect while waiting on addr 8
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("req_second_cycle", {31'b0, imem_bus.imem_req}, 32'd1);
        wait_accepts(2, 10);
        m_lat = 3;
        wait_accepts(3, 10);
        m_lat = 1;
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        wait_accepts(4, 10);
        check("seq_addr0", acc_log[0], 32'h0);
        check("seq_addr1", acc_log[1], 32'h4);
        check("seq_addr2", acc_log[2], 32'h8);
        check("redir_addr", acc_log[3], 32'h100);
        wait_valid(10);
        check("redir_pc_out", pc_out, 32'h104);
        check("redir_inst", inst_out, 32'hA5A5_0100);

        // Stall 4 cycles while a response lands -> HOLD, then release
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_hold_pc", pc_out, 32'h104);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_req0_a", {31'b0, imem_bus.imem_req}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_req0_b", {31'b0, imem_bus.imem_req}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_req0_c", {31'b0, imem_bus.imem_req}, 32'd0);
        check("hold_pc", pc_out, 32'h104);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("skid_pc_out", pc_out, 32'h108);
        check("skid_valid", {31'b0, out_valid}, 32'd1);

        // Redirect coinciding with rvalid under stall
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        check("rr_nop_valid", {31'b0, out_valid}, 32'd0);
        check("rr_nop_inst", inst_out, 32'h0);
        wait_accepts(acc_log.size() + 1, 10);
        check("rr_refetch", acc_log[acc_log.size() - 1], 32'h200);

        // Unaligned redirect target
        wait_req(10);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        wait_accepts(acc_log.size() + 1, 10);
        check("unaligned_addr", acc_log[acc_log.size() - 1], 32'h100);

        // Wrap-around at the top of the address space
        wait_req(10);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_accepts(acc_log.size() + 1, 10);
        check("wrap_addr", acc_log[acc_log.size() - 1], 32'hFFFF_FFFC);
        wait_valid(10);
        check("wrap_pc_out", pc_out, 32'h0);
        check("wrap_inst", inst_out, 32'h5A5A_FFFC);
        wait_accepts(acc_log.size() + 1, 10);
        check("wrap_next_addr", acc_log[acc_log.size() - 1], 32'h0);

        // imem_ready low for 3 cycles
        wait_req(10);
        a0 = acc_log.size();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check("nrdy_addr", imem_bus.imem_addr, 32'h4);
            check("nrdy_req", {31'b0, imem_bus.imem_req}, 32'd1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("nrdy_single_accept", acc_log.size(), a0 + 1);
        check("nrdy_accept_addr", acc_log[acc_log.size() - 1], 32'h4);

        // Reset pulsed mid-WAIT
        m_lat = 3;
        wait_accepts(acc_log.size() + 1, 10);
        check("pre_rst_addr", imem_bus.imem_addr, 32'h8);
        do_reset();
        m_lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_rst_req", {31'b0, imem_bus.imem_req}, 32'd1);
        wait_accepts(1, 10);
        check("post_rst_addr", acc_log[0], RESET_PC);

        // Randomized traffic
        lat_rand  = 1'b1;
        out_count = 0;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
                  $urandom(), $urandom_range(0, 99) < 70);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check("rand_progress", {31'b0, out_count > 20}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined MIPS CPU: owns the fetch PC, issues single-outstanding requests to instruction memory, and produces the `pc`/`inst` pair that the IF/ID pipeline register samples every cycle. The IF/ID register has no enable, so this unit implements stall by holding its outputs and flush by driving a NOP bubble. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_in`  in  1  hazard unit: hold current outputs.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; sampled by memory only on the accept cycle.
- `imem_ready`  in  1  request accepted when `imem_req && imem_ready`.
- `imem_rvalid`  in  1  response valid, at least 1 cycle after accept.
- `imem_rdata`  in  32  instruction word.
- `pc_out`  out  32  PC+4 of the instruction on `inst_out`; drives IF/ID `pcin`.
- `inst_out`  out  32  instruction word, or 32'h0 (NOP) when not valid; drives IF/ID `instin`.
- `out_valid`  out  1  `inst_out` holds a real instruction.

## Operation
- Reset values: state IDLE, `fetch_pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `pc_out`=0, `inst_out`=0, `out_valid`=0, drop flag=0, skid buffer empty.
- `imem_addr` = `fetch_pc` at all times. `imem_req` = 1 only in REQ.
- IDLE: always moves to REQ on the next edge.
- REQ: on accept, go to WAIT. On redirect, set `fetch_pc` to `redirect_pc`. If the redirect coincides with accept, go to WAIT with drop=1.
- WAIT, `imem_rvalid` with drop=1: discard the response, clear drop, go to REQ.
- WAIT, `imem_rvalid`, drop=0, no redirect:
  - Set `fetch_pc` to `fetch_pc`+4.
  - If the output is free (not `out_valid && stall_in`), load `inst_out`=`rdata`, `pc_out`=old `fetch_pc`+4, `out_valid`=1, and go to REQ.
  - Otherwise, write the skid buffer and go to HOLD.
- WAIT, redirect without `rvalid`: `fetch_pc` gets `redirect_pc`, drop=1, stay in WAIT.
- WAIT, redirect together with `rvalid`: discard the response, `fetch_pc` gets `redirect_pc`, go to REQ.
- HOLD: `imem_req`=0. When `stall_in`=0, move the skid buffer to the outputs and go to REQ. On redirect, discard the skid buffer, `fetch_pc` gets `redirect_pc`, go to REQ.
- Output register, priority order:
  1. Redirect: `out_valid`=0, `inst_out`=0. Redirect overrides stall.
  2. `stall_in && out_valid`: hold all outputs.
  3. Load, from a response or from the skid buffer.
  4. Otherwise: `out_valid`=0, `inst_out`=0, `pc_out` holds its value.
- Arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- `rst` asserted mid-operation returns everything to reset values immediately. Any in-flight response after `rst` deasserts arrives in IDLE/REQ and is ignored. Memory must not deliver `rvalid` without an accepted request after reset.

## Timing
- First request: `imem_req` rises in the 2nd cycle after `rst` deasserts.
- With zero-wait memory (ready=1, `rvalid` 1 cycle after accept):
  - Accept in cycle N, `rvalid` in N+1, outputs valid from N+2.
  - Sustained rate is one instruction per 2 cycles.
- Redirect in cycle N: outputs are NOP from N+1. The first request to the new PC is in N+1 if the unit was in REQ/HOLD, or in the cycle after the outstanding response if it was in WAIT.
- `out_valid` lasts one cycle per instruction unless held by `stall_in`.

## Structure
- `mips_pkg` holds:
  - fetch state enum (IDLE, REQ, WAIT, HOLD)
  - `NOP_INST`=32'h0
  - `PC_STEP`=32'd4
- Sub-module `if_skid_buf`: one-entry `{pc, inst}` holding register with load/clear/valid.
- The FSM, `fetch_pc`, drop flag and output register stay in `if_fetch_unit`.

## Test plan
- Reset, then zero-wait memory returning `imem_rdata` = addr ^ 32'hA5A5_0000:
  - `imem_addr` sequence is 0, 4, 8.
  - Outputs `pc_out` 4/8/12 with matching `inst_out`, each with `out_valid`=1.
- Redirect to 32'h0000_0100 while in WAIT for addr 8:
  - The addr-8 response is dropped and never appears on the outputs.
  - The next `imem_addr` is 32'h100, and the following output has `pc_out`=32'h104.
- `stall_in`=1 for 4 cycles while a response arrives:
  - Outputs hold the previous instruction and the unit enters HOLD with `imem_req`=0.
  - After release, the skid instruction appears the next cycle.
- Redirect and `imem_rvalid` in the same cycle, with `stall_in`=1: outputs go to NOP and `out_valid`=0 next cycle, and the refetch targets `redirect_pc`.
- `redirect_pc`=32'h0000_0103: `imem_addr` is 32'h100.
- `redirect_pc`=32'hFFFF_FFFC: next `imem_addr` is 0 and `pc_out` is 0 for that instruction.
- `imem_ready` low for 3 cycles: `imem_addr` stays stable and a single accept occurs.
- `rst` pulsed mid-WAIT: all outputs return to reset values, and the first fetch after release is at RESET_PC.
